// File: rtl/mux_n_reg_sel_if.sv
// Data, enable and select-handshake bundle for the registered N-channel mux.
// The master drives channel data and select requests; the slave returns status and output.
interface mux_n_reg_sel_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] D;
  logic                 EN;
  logic                 SEL_REQ;
  logic [SELW-1:0]      SEL_NEW;
  logic                 SEL_ACK;
  logic                 SEL_ERR;
  logic [SELW-1:0]      SEL_CUR;
  logic [WIDTH-1:0]     Z;
  logic                 ZV;

  modport master (
    output D, EN, SEL_REQ, SEL_NEW,
    input  SEL_ACK, SEL_ERR, SEL_CUR, Z, ZV
  );

  modport slave (
    input  D, EN, SEL_REQ, SEL_NEW,
    output SEL_ACK, SEL_ERR, SEL_CUR, Z, ZV
  );
endinterface

// File: rtl/mux_n_reg_sel.sv
// Registered N-channel mux with handshaked select changes, a blanking cycle,
// out-of-range rejection, an equal-data bypass and an optional second output stage.
module mux_n_reg_sel #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int PIPE  = 0
) (
  input logic             CK,
  input logic             RST,
  mux_n_reg_sel_if.slave  bus
);
  localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1;
  localparam int NSLOT = 2 ** SELW;
  localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

  typedef enum logic [1:0] {IDLE, BLANK, ACK} state_t;

  state_t           state_q;
  logic [SELW-1:0]  sel_cur_q;
  logic [SELW-1:0]  sel_old_q;
  logic             ack_q;
  logic             err_q;
  logic [WIDTH-1:0] z1_q, z1_d;
  logic             zv1_q, zv1_d;
  logic [WIDTH-1:0] ch [NSLOT];
  logic             sel_in_range;

  // Unused select codes read as zero so every SEL_CUR value indexes a defined slot.
  always_comb begin
    for (int k = 0; k < NSLOT; k++) ch[k] = '0;
    for (int k = 0; k < NCH; k++) ch[k] = bus.D[k*WIDTH +: WIDTH];
  end

  assign sel_in_range = ({1'b0, bus.SEL_NEW} < NCH_W);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= IDLE;
      sel_cur_q <= '0;
      sel_old_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.SEL_REQ) begin
            if (sel_in_range) begin
              state_q   <= BLANK;
              sel_old_q <= sel_cur_q;
              sel_cur_q <= bus.SEL_NEW;
            end else begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        BLANK: begin
          state_q <= ACK;
          ack_q   <= 1'b1;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    z1_d  = z1_q;
    zv1_d = 1'b0;
    // During BLANK the old channel may still be on the wire; only identical data is safe.
    if (bus.EN && (state_q != BLANK || ch[sel_old_q] == ch[sel_cur_q])) begin
      z1_d  = ch[sel_cur_q];
      zv1_d = 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      z1_q  <= '0;
      zv1_q <= 1'b0;
    end else begin
      z1_q  <= z1_d;
      zv1_q <= zv1_d;
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] z2_q;
      logic             zv2_q;

      always_ff @(posedge CK) begin
        if (RST) begin
          z2_q  <= '0;
          zv2_q <= 1'b0;
        end else begin
          z2_q  <= z1_q;
          zv2_q <= zv1_q;
        end
      end

      assign bus.Z  = z2_q;
      assign bus.ZV = zv2_q;
    end else begin : g_nopipe
      assign bus.Z  = z1_q;
      assign bus.ZV = zv1_q;
    end
  endgenerate

  assign bus.SEL_ACK = ack_q;
  assign bus.SEL_ERR = err_q;
  assign bus.SEL_CUR = sel_cur_q;
endmodule

// File: tb/tb_mux_n_reg_sel.sv
// Scoreboard bench for mux_n_reg_sel: stimulus pushes hand-computed expectations,
// a monitor pops and compares them one clock edge later.
module tb_mux_n_reg_sel;
  logic CK;
  logic RST;

  mux_n_reg_sel_if #(.WIDTH(8), .NCH(4)) a_if ();
  mux_n_reg_sel_if #(.WIDTH(8), .NCH(3)) b_if ();
  mux_n_reg_sel_if #(.WIDTH(8), .NCH(4)) c_if ();

  mux_n_reg_sel #(.WIDTH(8), .NCH(4), .PIPE(0)) u_a (.CK(CK), .RST(RST), .bus(a_if.slave));
  mux_n_reg_sel #(.WIDTH(8), .NCH(3), .PIPE(0)) u_b (.CK(CK), .RST(RST), .bus(b_if.slave));
  mux_n_reg_sel #(.WIDTH(8), .NCH(4), .PIPE(1)) u_c (.CK(CK), .RST(RST), .bus(c_if.slave));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    int          dut;
    string       name;
    logic [7:0]  z;
    logic        zv;
    logic        ack;
    logic        err;
    logic [1:0]  cur;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input bit ok, input string name);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", name);
    end
  endtask

  task automatic push(input int dut, input string name, input logic [7:0] z,
                      input logic zv, input logic ack, input logic err, input logic [1:0] cur);
    exp_t e;
    e.dut = dut; e.name = name; e.z = z; e.zv = zv; e.ack = ack; e.err = err; e.cur = cur;
    sb_q.push_back(e);
  endtask

  // Inputs change on the falling edge; expectations pushed before this call
  // describe the outputs after the next rising edge.
  task automatic tick();
    @(negedge CK);
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    exp_t       e;
    logic [7:0] z;
    logic       zv, ack, err;
    logic [1:0] cur;
    bit         ok;
    forever begin
      @(posedge CK);
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.dut)
          0:       begin z = a_if.Z; zv = a_if.ZV; ack = a_if.SEL_ACK; err = a_if.SEL_ERR; cur = a_if.SEL_CUR; end
          1:       begin z = b_if.Z; zv = b_if.ZV; ack = b_if.SEL_ACK; err = b_if.SEL_ERR; cur = b_if.SEL_CUR; end
          default: begin z = c_if.Z; zv = c_if.ZV; ack = c_if.SEL_ACK; err = c_if.SEL_ERR; cur = c_if.SEL_CUR; end
        endcase
        ok = (z === e.z) && (zv === e.zv) && (ack === e.ack) && (err === e.err) && (cur === e.cur);
        if (!ok)
          $display("  %s: got z=%h zv=%b ack=%b err=%b cur=%0d, expected z=%h zv=%b ack=%b err=%b cur=%0d",
                   e.name, z, zv, ack, err, cur, e.z, e.zv, e.ack, e.err, e.cur);
        check(ok, e.name);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_seen;
    RST = 1'b1;
    a_if.D = {8'h44, 8'h33, 8'h22, 8'h11}; a_if.EN = 1'b1; a_if.SEL_REQ = 1'b0; a_if.SEL_NEW = 2'd0;
    b_if.D = {8'h33, 8'h22, 8'h11};        b_if.EN = 1'b0; b_if.SEL_REQ = 1'b0; b_if.SEL_NEW = 2'd0;
    c_if.D = {8'h44, 8'h33, 8'h22, 8'h00}; c_if.EN = 1'b0; c_if.SEL_REQ = 1'b0; c_if.SEL_NEW = 2'd0;

    // 1. Reset dominates EN, then first capture from channel 0.
    push(0, "reset_cycle1", 8'h00, 0, 0, 0, 2'd0); tick();
    push(0, "reset_cycle2", 8'h00, 0, 0, 0, 2'd0);
    push(2, "reset_pipe",   8'h00, 0, 0, 0, 2'd0); tick();
    RST = 1'b0;
    push(0, "first_capture", 8'h11, 1, 0, 0, 2'd0); tick();

    // 2. Switch 0 -> 2 with EN=1: old channel on the request edge, blank, then new.
    a_if.SEL_REQ = 1'b1; a_if.SEL_NEW = 2'd2;
    push(0, "switch_t1_blank", 8'h11, 1, 0, 0, 2'd2); tick();
    push(0, "switch_t2_ack",   8'h11, 0, 1, 0, 2'd2); tick();
    a_if.SEL_REQ = 1'b0;
    push(0, "switch_t3_new",   8'h33, 1, 0, 0, 2'd2); tick();
    push(0, "switch_idle",     8'h33, 1, 0, 0, 2'd2); tick();

    // 3. Equal-data bypass: ch0 == ch2, switch 2 -> 0 keeps ZV high.
    a_if.D = {8'h44, 8'h33, 8'h22, 8'h33};
    push(0, "bypass_pre",   8'h33, 1, 0, 0, 2'd2); tick();
    a_if.SEL_REQ = 1'b1; a_if.SEL_NEW = 2'd0;
    push(0, "bypass_req",   8'h33, 1, 0, 0, 2'd0); tick();
    push(0, "bypass_blank", 8'h33, 1, 1, 0, 2'd0); tick();
    a_if.SEL_REQ = 1'b0;
    push(0, "bypass_after", 8'h33, 1, 0, 0, 2'd0); tick();

    // 4. NCH=3: reject select 3, request held through ACK must not retrigger.
    b_if.EN = 1'b1;
    push(1, "rej_pre",   8'h11, 1, 0, 0, 2'd0); tick();
    b_if.SEL_REQ = 1'b1; b_if.SEL_NEW = 2'd3;
    push(1, "rej_ack",   8'h11, 1, 1, 1, 2'd0); tick();
    push(1, "rej_clear", 8'h11, 1, 0, 0, 2'd0); tick();
    b_if.SEL_REQ = 1'b0;
    push(1, "rej_noretrig", 8'h11, 1, 0, 0, 2'd0); tick();
    // Highest legal select on NCH=3 is accepted.
    b_if.SEL_REQ = 1'b1; b_if.SEL_NEW = 2'd2;
    push(1, "top_sel_req", 8'h11, 1, 0, 0, 2'd2); tick();
    push(1, "top_sel_ack", 8'h11, 0, 1, 0, 2'd2); tick();
    b_if.SEL_REQ = 1'b0;
    push(1, "top_sel_new", 8'h33, 1, 0, 0, 2'd2); tick();

    // 5. Reset during BLANK aborts the switch without an ACK.
    a_if.SEL_REQ = 1'b1; a_if.SEL_NEW = 2'd1;
    push(0, "midrst_req",   8'h33, 1, 0, 0, 2'd1); tick();
    RST = 1'b1; a_if.SEL_REQ = 1'b0;
    push(0, "midrst_reset", 8'h00, 0, 0, 0, 2'd0); tick();
    RST = 1'b0;
    push(0, "midrst_noack1", 8'h33, 1, 0, 0, 2'd0); tick();
    push(0, "midrst_noack2", 8'h33, 1, 0, 0, 2'd0); tick();

    // 6. PIPE=1: two-cycle latency, EN bubble, ACK not delayed.
    c_if.EN = 1'b1; c_if.D[7:0] = 8'h01;
    push(2, "pipe_e1", 8'h00, 0, 0, 0, 2'd0); tick();
    c_if.EN = 1'b0; c_if.D[7:0] = 8'h02;
    push(2, "pipe_e2", 8'h01, 1, 0, 0, 2'd0); tick();
    c_if.EN = 1'b1; c_if.D[7:0] = 8'h03;
    push(2, "pipe_e3", 8'h01, 0, 0, 0, 2'd0); tick();
    push(2, "pipe_e4", 8'h03, 1, 0, 0, 2'd0); tick();
    c_if.SEL_REQ = 1'b1; c_if.SEL_NEW = 2'd2;
    push(2, "pipe_sw_t1", 8'h03, 1, 0, 0, 2'd2); tick();
    push(2, "pipe_sw_t2", 8'h03, 1, 1, 0, 2'd2); tick();
    c_if.SEL_REQ = 1'b0;
    push(2, "pipe_sw_t3", 8'h03, 0, 0, 0, 2'd2); tick();
    push(2, "pipe_sw_t4", 8'h33, 1, 0, 0, 2'd2); tick();

    tick();
    n_seen = n_tests;
    check(sb_q.size() == 0, "scoreboard_drained");
    check(n_seen == 31, "all_expectations_checked");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_n_reg_sel.md
Name: mux_n_reg_sel

Overview:
- Parametrised, registered N-channel, WIDTH-bit multiplexer.
- Successor to the 2:1 combinational mux cell. Adds:
  - select changes through a request/acknowledge handshake, with one blanking cycle;
  - registered output with an optional extra pipeline stage;
  - rejection of out-of-range selects;
  - an equal-data bypass that keeps the output valid across a switch.
- Used wherever datapath sources are switched at run time without glitching downstream logic.

Parameters:
- WIDTH, 8: bits per channel, ≥1.
- NCH, 4: number of input channels, 2..16.
- SELW, clog2(NCH) (derived, min 1): select width.
- PIPE, 0: 0 gives a single output register; 1 adds a second output register stage.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- D  input  NCH*WIDTH  channel data, flattened; channel k is D[k*WIDTH +: WIDTH].
- EN  input  1  capture enable.
- SEL_REQ  input  1  select-change request; held high until SEL_ACK.
- SEL_NEW  input  SELW  requested channel; stable while SEL_REQ=1.
- SEL_ACK  output  1  one-cycle pulse that completes a request (accepted or rejected).
- SEL_ERR  output  1  one-cycle pulse, coincident with SEL_ACK, when the request is rejected.
- SEL_CUR  output  SELW  active channel.
- Z  output  WIDTH  registered mux output.
- ZV  output  1  Z holds freshly captured data.

Behaviour:
- Reset (RST=1 at an edge, from any state, mid-switch included):
  - state=IDLE, SEL_CUR=0, Z=0, ZV=0, SEL_ACK=0, SEL_ERR=0.
  - Both pipe stages are cleared when PIPE=1.
  - No ACK is issued for a request aborted by reset.
- FSM states: IDLE, BLANK, ACK.
  - IDLE → BLANK when SEL_REQ=1 and SEL_NEW<NCH. SEL_CUR<=SEL_NEW on the same edge; the old value is held internally as sel_old for one cycle.
  - IDLE → ACK when SEL_REQ=1 and SEL_NEW≥NCH. SEL_ERR<=1; SEL_CUR is unchanged.
  - BLANK → ACK unconditionally after 1 cycle.
  - ACK → IDLE unconditionally. SEL_ACK=1 in the ACK state only, and SEL_ERR is cleared on leaving ACK.
  - SEL_REQ is ignored in BLANK and ACK, so a request still high in ACK does not retrigger. The requester must drop SEL_REQ on the edge where it samples SEL_ACK=1.
- Capture, stage 1:
  - IDLE or ACK with EN=1: Z1<=D[SEL_CUR], ZV1<=1.
  - EN=0: Z1 holds, ZV1<=0.
  - BLANK: Z1 holds and ZV1<=0. Exception (equal-data bypass): if EN=1 and D[sel_old]==D[SEL_CUR], then Z1<=D[SEL_CUR], ZV1<=1.
- Simultaneous EN=1 and accepted SEL_REQ in IDLE: that edge captures from the OLD channel. The new channel is first captured on the BLANK→ACK edge only via the bypass; otherwise on the ACK→IDLE edge.
- Output and latency:
  - PIPE=0: Z=Z1, ZV=ZV1; latency 1 cycle from D/EN to Z.
  - PIPE=1: Z/ZV are Z1/ZV1 registered once more; latency 2 cycles, and EN=0 bubbles propagate as ZV=0.
  - SEL_ACK, SEL_ERR and SEL_CUR are never delayed by PIPE.
- Out-of-range: SEL_NEW in NCH..2^SELW−1 is rejected without a blanking cycle. Capture continues from the unchanged SEL_CUR.
- Same-channel request (SEL_NEW==SEL_CUR): a normal accepted switch with a BLANK cycle. The bypass always applies in this case, so ZV is unbroken when EN=1.
- No combinational path from any input to any output.

Test Plan:
1. Reset/capture. Setup: WIDTH=8, NCH=4, PIPE=0, D={ch3=0x44, ch2=0x33, ch1=0x22, ch0=0x11}; RST for 2 cycles, then EN=1.
   - Required: during reset Z=0x00, ZV=0, SEL_CUR=0.
   - Required: first edge after reset gives Z=0x11, ZV=1.
2. Switch. Setup: SEL_REQ=1, SEL_NEW=2 at edge t.
   - t+1: SEL_CUR=2, state BLANK, Z=0x11.
   - t+2: ZV=0, SEL_ACK=1.
   - t+3: Z=0x33, ZV=1, SEL_ACK=0.
3. Bypass. Setup: ch2=0x33, ch0=0x33; switch 2→0 with EN=1.
   - Required: ZV stays 1 every cycle and Z=0x33 throughout.
4. Reject. Setup: NCH=3, SELW=2, SEL_NEW=3.
   - Required: next edge gives SEL_ACK=1, SEL_ERR=1, SEL_CUR unchanged.
   - Required: no ZV drop.
5. Reset mid-switch. Setup: RST=1 in the BLANK cycle.
   - Required: next edge gives SEL_CUR=0, Z=0, ZV=0, and no SEL_ACK pulse afterwards.
6. Pipeline. Setup: PIPE=1, EN toggling 1,0,1 with ch0 counting 0x01, 0x02, 0x03.
   - Required: Z/ZV follow 2 cycles later: (0x01,1), (0x01,0), (0x03,1).
   - Required: SEL_ACK timing identical to scenario 2.
